// File: rtl/dma_send_pkg.sv
// Shared constants and types for the DMA source arbiter: FSM state
// encodings, gap counter width, grant index width and a saturating
// increment helper used by the optional grant statistics.
package dma_send_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int GAP_CNT_W  = 4;
  localparam int GRANT_ID_W = 3;
  localparam int STAT_W     = 16;

  // Increment a 16-bit counter, sticking at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/dma_src_arbiter_rr_pick.sv
// Round-robin picker: returns the first set bit of `eligible` found by
// searching upward from `ptr`, wrapping from NUM_SRC-1 back to 0.
module rr_pick
  import dma_send_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]    eligible,
  input  logic [GRANT_ID_W-1:0] ptr,
  output logic [NUM_SRC-1:0]    onehot,
  output logic [GRANT_ID_W-1:0] index,
  output logic                  any
);

  int   pos_s;
  logic found_s;

  // Scan NUM_SRC positions starting at ptr; the first eligible one wins.
  always_comb begin
    onehot  = '0;
    index   = '0;
    any     = 1'b0;
    found_s = 1'b0;
    pos_s   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos_s = int'(ptr) + k;
      if (pos_s >= NUM_SRC) begin
        pos_s = pos_s - NUM_SRC;
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && eligible[pos_s]) begin
        found_s        = 1'b1;
        onehot[pos_s]  = 1'b1;
        index          = pos_s[GRANT_ID_W-1:0];
        any            = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/dma_src_arbiter.sv
// DMA source arbiter: round-robin selection of one ready source frame,
// registered hand-off to the packer as a one-cycle strobe, followed by a
// fixed idle gap. Optional macro ARB_STATS_EN adds per-source saturating
// 16-bit grant counters on output grant_cnt.
module dma_src_arbiter
  import dma_send_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 4064,
  parameter int GAP_CYCLES = 2
) (
`ifdef ARB_STATS_EN
  output logic [NUM_SRC*16-1:0]         grant_cnt,
`endif
  input  logic                          m_axis_c2h_aclk,
  input  logic                          rst,
  input  logic                          arb_en,
  input  logic [NUM_SRC-1:0]            src_mask,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          data_valid,
  output logic [DATA_WIDTH-1:0]         data,
  input  logic                          data_next,
  output logic [GRANT_ID_W-1:0]         grant_id,
  output logic [1:0]                    arb_state
);

  arb_state_t              state_r;
  arb_state_t              state_nxt_s;
  logic [GAP_CNT_W-1:0]    gap_cnt_r;
  logic [GRANT_ID_W-1:0]   rr_ptr_r;
  logic [NUM_SRC-1:0]      eligible_s;
  logic [NUM_SRC-1:0]      pick_onehot_s;
  logic [GRANT_ID_W-1:0]   pick_index_s;
  logic                    pick_any_s;
  logic                    grant_s;
  logic [DATA_WIDTH-1:0]   frame_s;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    data_valid_r;
  logic [GRANT_ID_W-1:0]   grant_id_r;

  assign eligible_s = src_valid & ~src_mask;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
    .eligible (eligible_s),
    .ptr      (rr_ptr_r),
    .onehot   (pick_onehot_s),
    .index    (pick_index_s),
    .any      (pick_any_s)
  );

  // Next-state logic; a grant is only possible from IDLE outside reset.
  always_comb begin
    state_nxt_s = ST_IDLE;
    grant_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rst && arb_en && data_next && pick_any_s) begin
          grant_s     = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_GAP;
      ST_GAP: begin
        if (gap_cnt_r <= GAP_CNT_W'(1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Accept pulse back to the granted source, same cycle as the grant.
  always_comb begin
    if (grant_s) begin
      src_ready = pick_onehot_s;
    end else begin
      src_ready = '0;
    end
  end

  // Select the frame of the picked source.
  always_comb begin
    frame_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick_onehot_s[i]) begin
        frame_s = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        frame_s = frame_s;
      end
    end
  end

  // State, round-robin pointer, gap counter and registered packer outputs.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gap_cnt_r    <= '0;
      rr_ptr_r     <= '0;
      data_r       <= '0;
      data_valid_r <= 1'b0;
      grant_id_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      data_valid_r <= grant_s;
      if (grant_s) begin
        data_r     <= frame_s;
        grant_id_r <= pick_index_s;
        if (pick_index_s == GRANT_ID_W'(NUM_SRC - 1)) begin
          rr_ptr_r <= '0;
        end else begin
          rr_ptr_r <= pick_index_s + 3'd1;
        end
      end
      if (state_r == ST_ISSUE) begin
        gap_cnt_r <= GAP_CNT_W'(GAP_CYCLES);
      end else if (state_r == ST_GAP && gap_cnt_r != '0) begin
        gap_cnt_r <= gap_cnt_r - 4'd1;
      end else begin
        gap_cnt_r <= gap_cnt_r;
      end
    end
  end

  assign data_valid = data_valid_r;
  assign data       = data_r;
  assign grant_id   = grant_id_r;
  assign arb_state  = state_r;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_r [NUM_SRC];

  // Per-source saturating grant counters.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        grant_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_s && pick_onehot_s[i]) begin
          grant_cnt_r[i] <= sat_inc16(grant_cnt_r[i]);
        end
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      grant_cnt[i*16 +: 16] = grant_cnt_r[i];
    end
  end
`endif

endmodule
